// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: opcode constants for the main decoder,
// the canonical NOP encoding, and the fetch-unit state encoding.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_STORE  = 7'b010_0011;
   localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
   localparam logic [6:0] OP_BRANCH = 7'b110_0011;
   localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
   localparam logic [6:0] OP_JAL    = 7'b110_1111;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // RUN: nothing in flight; WAIT: one request in flight, response kept;
   // DROP: one request in flight, response discarded (stale after redirect).
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer used by the fetch unit.
// Ports: clk, reset (sync, active-high), flush (empties buffer), push/push_data,
//        pop, head_data (oldest entry), count, full, empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   // Pointer and occupancy tracking; flush behaves like reset.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset; the occupancy count qualifies every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: holds the PC, issues one word fetch at a time
// over a valid/ready request channel, buffers responses in order, and hands
// instr/op/pc to decode with a valid/ready handshake. A redirect flushes the
// buffer and drops any response still in flight.
// Ports:
//   clk, reset (sync, active-high)
//   imem_req_valid/ready/addr  - fetch request channel
//   imem_rsp_valid/data        - in-order fetch responses
//   redirect_valid/pc          - change of flow
//   instr_valid/ready, instr, op, instr_pc, instr_pc_plus4 - decode interface
// Build option: IFETCH_BYPASS_EN - a kept response arriving while the buffer is
// empty is presented to decode combinationally in the same cycle.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [6:0]      op,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned EW = 2 * XLEN;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
   logic [XLEN-1:0] req_pc;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            fifo_push, fifo_pop;
   logic [EW-1:0]   fifo_head;
   logic            credit_ok, req_fire, rsp_keep, bypass;
   logic            unused_redirect_lsb;

   // Redirect targets are forced word-aligned; the low bits are ignored.
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Request issue and response acceptance. Credit counts the kept in-flight
   // response; a same-cycle dequeue deliberately does not free a slot.
   always_comb begin
      credit_ok      = (state == WAIT) ? (fifo_count < CW'(FIFO_DEPTH - 1)) : ~fifo_full;
      imem_req_valid = ~reset & ~redirect_valid & credit_ok &
                       ((state == RUN) | ((state == WAIT) & imem_rsp_valid));
      imem_req_addr  = fetch_pc;
      req_fire       = imem_req_valid & imem_req_ready;
      rsp_keep       = ~reset & ~redirect_valid & (state == WAIT) & imem_rsp_valid;
   end

`ifdef IFETCH_BYPASS_EN
   assign bypass = rsp_keep & fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed response consumed by decode this cycle is not buffered.
   assign fifo_push = rsp_keep & ~(bypass & instr_ready);
   assign fifo_pop  = ~fifo_empty & instr_ready & ~redirect_valid;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fetch_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data ({imem_rsp_data, req_pc}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State, fetch PC and PC of the outstanding request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (req_fire) req_pc <= fetch_pc;
      end
   end

   // Next state and next fetch PC; redirect overrides normal sequencing.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      if (redirect_valid) begin
         fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
         // Anything still outstanding after this cycle is now stale.
         state_nxt    = ((state != RUN) && !imem_rsp_valid) ? DROP : RUN;
      end else begin
         case (state)
            RUN:     if (req_fire) state_nxt = WAIT;
            WAIT:    if (imem_rsp_valid) state_nxt = req_fire ? WAIT : RUN;
            DROP:    if (imem_rsp_valid) state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
         if (req_fire) fetch_pc_nxt = fetch_pc + XLEN'(4);
      end
   end

   // Decode-side view: bypassed response or buffer head, zero when idle.
   always_comb begin
      instr_valid    = 1'b0;
      instr          = '0;
      instr_pc       = '0;
      instr_pc_plus4 = '0;
      if (bypass) begin
         instr_valid = 1'b1;
         instr       = imem_rsp_data;
         instr_pc    = req_pc;
      end else if (!fifo_empty) begin
         instr_valid       = 1'b1;
         {instr, instr_pc} = fifo_head;
      end
      if (instr_valid) instr_pc_plus4 = instr_pc + XLEN'(4);
      op = instr[6:0];
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a small memory responder with
// programmable latency plus hand-derived expected PCs and addresses.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;

   int          checks;
   int          failures;
   int          lat;
   int          pend_wait;
   int          consumed;
   int          c0;
   logic        pend;
   logic        last_acc;
   logic        found;
   logic        chk_req;
   logic        chk_stream;
   logic [31:0] pend_addr;
   logic [31:0] exp_req;
   logic [31:0] exp_pc;
   logic [31:0] dexp;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .op             (op),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4)
   );

   always #5 clk = ~clk;

   // Memory contents derived from the word address; low 7 bits vary per word.
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[29:5], a[8:2]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes, check consumed instructions, advance memory.
   task automatic cycle();
      logic        acc;
      logic        rd;
      logic [31:0] a;
      logic [31:0] d;
      #1;
      acc = imem_req_valid & imem_req_ready;
      a   = imem_req_addr;
      rd  = imem_rsp_valid;
      if (chk_req && acc) begin
         check_eq("req_addr", a, exp_req);
         exp_req = exp_req + 32'd4;
      end
      if (chk_stream && instr_valid && instr_ready && !redirect_valid && !reset) begin
         d = memfn(exp_pc);
         check_eq("instr_pc", instr_pc, exp_pc);
         check_eq("instr", instr, d);
         check_eq("op", 32'(op), 32'(d[6:0]));
         check_eq("pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
         exp_pc   = exp_pc + 32'd4;
         consumed = consumed + 1;
      end
      last_acc = acc;
      @(posedge clk);
      #1;
      if (rd) pend = 1'b0;
      if (acc) begin
         pend      = 1'b1;
         pend_addr = a;
         pend_wait = lat - 1;
      end else if (pend && pend_wait > 0) begin
         pend_wait = pend_wait - 1;
      end
      imem_rsp_valid = pend && (pend_wait == 0);
      imem_rsp_data  = pend ? memfn(pend_addr) : 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0; reset = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      checks = 0; failures = 0; lat = 1; pend = 1'b0; pend_wait = 0; pend_addr = '0;
      consumed = 0; last_acc = 1'b0; chk_req = 1'b0; chk_stream = 1'b0;
      exp_req = '0; exp_pc = '0; found = 1'b0; c0 = 0;

      // Reset state
      #1;
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_instr", instr, 32'd0);
      check_eq("rst_op", 32'(op), 32'd0);
      check_eq("rst_instr_pc", instr_pc, 32'd0);
      check_eq("rst_pc_plus4", instr_pc_plus4, 32'd0);
      check_eq("rst_first_req", 32'(imem_req_valid), 32'd1);
      check_eq("rst_first_addr", imem_req_addr, 32'h0);

      // Streaming: sequential addresses and PCs, 1-cycle memory
      exp_req = 32'h0; exp_pc = 32'h0; chk_req = 1'b1; chk_stream = 1'b1;
      instr_ready = 1'b1; imem_req_ready = 1'b1; consumed = 0;
      repeat (20) cycle();
      check_eq("t1_throughput", 32'(consumed >= 10), 32'd1);

      // Decode stall: buffer fills to two, requests stop, head holds
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (i >= 4) begin
            dexp = memfn(exp_pc);
            check_eq("t2_hold_valid", 32'(instr_valid), 32'd1);
            check_eq("t2_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("t2_hold_pc", instr_pc, exp_pc);
            check_eq("t2_hold_instr", instr, dexp);
         end
         cycle();
      end
      imem_req_ready = 1'b0; instr_ready = 1'b1; c0 = consumed;
      repeat (4) cycle();
      check_eq("t2_drained", 32'(consumed - c0), 32'd2);
      #1;
      check_eq("t2_empty", 32'(instr_valid), 32'd0);

      // Redirect while WAIT, response three cycles away
      lat = 3; imem_req_ready = 1'b1; found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         cycle();
         found = last_acc;
      end
      check_eq("t3_accept", 32'(found), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      #1;
      check_eq("t3_redir_noreq", 32'(imem_req_valid), 32'd0);
      cycle();
      redirect_valid = 1'b0; exp_req = 32'h100; lat = 1;
      #1;
      check_eq("t3_drop_valid", 32'(instr_valid), 32'd0);
      check_eq("t3_drop_noreq", 32'(imem_req_valid), 32'd0);
      cycle();
      #1;
      check_eq("t3_stale_valid", 32'(instr_valid), 32'd0);
      check_eq("t3_stale_noreq", 32'(imem_req_valid), 32'd0);
      cycle();
      #1;
      check_eq("t3_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("t3_req_addr", imem_req_addr, 32'h100);
      exp_pc = 32'h100; c0 = consumed;
      repeat (10) cycle();
      check_eq("t3_resume", 32'(consumed - c0 >= 4), 32'd1);

      // Redirect to an unaligned target in the same cycle as a response
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         cycle();
         found = last_acc;
      end
      check_eq("t4_accept", 32'(found), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
      cycle();
      redirect_valid = 1'b0; exp_req = 32'h200; exp_pc = 32'h200;
      #1;
      check_eq("t4_flushed", 32'(instr_valid), 32'd0);
      check_eq("t4_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("t4_req_addr", imem_req_addr, 32'h200);
      c0 = consumed;
      repeat (8) cycle();
      check_eq("t4_resume", 32'(consumed - c0 >= 3), 32'd1);

      // Fetch PC wrap at the top of the address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      cycle();
      redirect_valid = 1'b0; exp_req = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC;
      #1;
      check_eq("t5_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      cycle();
      #1;
      check_eq("t5_wrap_addr", imem_req_addr, 32'h0);
      c0 = consumed;
      repeat (8) cycle();
      check_eq("t5_resume", 32'(consumed - c0 >= 3), 32'd1);

      // Reset mid-WAIT with a buffered instruction; stale response in RUN
      instr_ready = 1'b0; lat = 3; chk_stream = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      cycle();
      redirect_valid = 1'b0; exp_req = 32'h300;
      cycle();
      cycle();
      cycle();
      cycle();
      #1;
      check_eq("t6_buf_valid", 32'(instr_valid), 32'd1);
      check_eq("t6_buf_pc", instr_pc, 32'h300);
      check_eq("t6_wait_noreq", 32'(imem_req_valid), 32'd0);
      reset = 1'b1; chk_req = 1'b0;
      #1;
      check_eq("t6_rst_noreq", 32'(imem_req_valid), 32'd0);
      cycle();
      reset = 1'b0; imem_req_ready = 1'b0; lat = 1;
      #1;
      check_eq("t6_post_valid", 32'(instr_valid), 32'd0);
      check_eq("t6_post_pc", instr_pc, 32'd0);
      check_eq("t6_post_req", 32'(imem_req_valid), 32'd1);
      check_eq("t6_post_addr", imem_req_addr, 32'h0);
      cycle();
      #1;
      check_eq("t6_stale_ignored", 32'(instr_valid), 32'd0);
      cycle();
      #1;
      check_eq("t6_after_stale", 32'(instr_valid), 32'd0);
      check_eq("t6_req_addr", imem_req_addr, 32'h0);
      imem_req_ready = 1'b1; instr_ready = 1'b1;
      chk_req = 1'b1; exp_req = 32'h0; chk_stream = 1'b1; exp_pc = 32'h0;
      c0 = consumed;
      repeat (8) cycle();
      check_eq("t6_resume", 32'(consumed - c0 >= 3), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
